regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter and sequencer for the 64-bit, 32-entry integer register file. It shares the file's single write port between two sources:
- the primary pipeline writeback, which has priority and no backpressure;
- a secondary long-latency source (multiplier/divider/load-miss return), which has valid/ready handshaking and a small queue.

It also keeps a per-register busy scoreboard for the hazard unit, and can stall the pipeline to prevent secondary starvation. It sits between the writeback stage and the register file's RegWrite/wa/wd inputs.

## Interface
- DATA_WIDTH, 64, write data width
- ADDRESS_WIDTH, 5, register address width
- FIFO_DEPTH, 2, secondary queue entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive lost arbitrations before stall_p
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset rst, asynchronous, active-high
- p_valid  in  1  primary writeback request
- p_wa  in  ADDRESS_WIDTH  primary destination
- p_wd  in  DATA_WIDTH  primary data
- s_valid  in  1  secondary request
- s_ready  out  1  secondary accepted when s_valid&&s_ready at posedge
- s_wa  in  ADDRESS_WIDTH  secondary destination
- s_wd  in  DATA_WIDTH  secondary data
- RegWrite  out  1  register file write enable (registered)
- wa  out  ADDRESS_WIDTH  register file write address (registered)
- wd  out  DATA_WIDTH  register file write data (registered)
- busy  out  2**ADDRESS_WIDTH  bit a set while a secondary write to register a is queued or not yet granted
- stall_p  out  1  pipeline must hold p_valid low this cycle (registered)

## Operation
- Address 0 is discarded:
  - p_valid with p_wa==0 is treated as no request.
  - A secondary transfer with s_wa==0 is accepted and dropped; it is not enqueued and busy is not set.
- s_ready = !fifo_full && !busy[s_wa] (combinational). A duplicate destination is never in flight, which preserves ordering per register.
- Arbitration each posedge, in priority order:
  1. If stall_p is high and FIFO is non-empty: grant FIFO head (pop).
  2. Else if p_valid and p_wa!=0: grant primary.
  3. Else if FIFO is non-empty: grant FIFO head (pop).
  4. Else: RegWrite <= 0.
- On a grant: RegWrite<=1, wa/wd <= granted address/data.
- busy[a] is set on enqueue of a and cleared on pop of a. Set and clear of the same bit in one cycle cannot occur, because s_ready blocks the enqueue.
- Starvation counter (0..STARVE_LIMIT):
  - increments when the FIFO is non-empty and the primary is granted;
  - clears when the FIFO pops or is empty;
  - stall_p <= 1 on the posedge where the counter reaches STARVE_LIMIT;
  - stall_p <= 0 after the pop it forces.
- Contract:
  - Primary must not assert p_valid while stall_p is high.
  - Primary must not write a register whose busy bit is set; the hazard unit guarantees this.
  - The bench checks both with assertions. The arbiter never reorders.
- FSM for the stall: IDLE (stall_p=0) -> STALL when the counter reaches STARVE_LIMIT; STALL -> IDLE after one pop.

## Timing
- Reset values: RegWrite=0, wa=0, wd=0, stall_p=0, busy=0, FIFO empty, counter=0, FSM=IDLE. After reset, s_ready=1.
- Reset mid-operation flushes queued secondary writes; they are lost and not written.
- Primary latency: request sampled at posedge N → RegWrite high in cycle N+1 → the file writes on the negedge inside N+1.
- Secondary latency:
  - enqueued at posedge N, earliest grant at posedge N+1, RegWrite high in cycle N+2;
  - no bypass.
- FIFO full: s_ready=0. A simultaneous pop frees a slot only from the next cycle, since s_ready uses registered full.
- Throughput: one write per cycle total.

## Configuration
- WB_ARB_STARVE_GUARD_EN defined: starvation counter and stall FSM present, as described above.
- Undefined: counter and FSM are removed, stall_p is tied 0, and strict primary priority applies. Secondary progress relies on primary idle cycles.

## Structure
- Package wb_arb_pkg holds:
  - a wb_req_t struct {valid, wa, wd} sized from the package localparams REG_ADDR_W=5 and REG_DATA_W=64;
  - the stall FSM state enum.
- Sub-module wb_arb_fifo: a synchronous FIFO of wb_req_t with push/pop/full/empty, reset-clearable.

## Test plan
- Reset, then p_valid=1, p_wa=5, p_wd=0xAA → RegWrite=1, wa=5, wd=0xAA in the next cycle; busy stays 0.
- s push wa=7, wd=0x11 with primary idle → busy[7]=1 immediately after the push edge; write of 7/0x11 two cycles after acceptance; busy[7]=0 after the pop.
- Push s wa=3, then attempt s wa=3 again → s_ready=0 until the first write is granted.
- FIFO holds 2 entries with continuous primary traffic → stall_p=1 after 4 primary grants. The next grant is the FIFO head, then stall_p=0. With the macro off, stall_p never rises.
- s_wa=0 and p_wa=0 requests → no RegWrite, busy unchanged, s_ready=1.
- Assert rst with 2 queued entries → FIFO empty, busy=0, RegWrite=0 immediately; no stale write after deassert.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter: the queued
// secondary request and the stall FSM state encoding.
package wb_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] wa;
        logic [REG_DATA_W-1:0] wd;
    } wb_req_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } stall_state_e;

endpackage

// File: rtl/wb_arb_fifo.sv
// Small synchronous FIFO holding secondary writeback requests.
// Full/empty come from registered pointers, so a pop only frees a slot
// for the push side on the following cycle. Reset flushes all entries.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push_i,
    input  wb_req_t din_i,
    input  logic    pop_i,
    output wb_req_t head_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int PW = $clog2(DEPTH);

    wb_req_t    mem_q [DEPTH];
    logic [PW:0] wr_q, rd_q;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign head_o  = mem_q[rd_q[PW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o)
                wr_q <= wr_q + 1'b1;
            if (pop_i && !empty_o)
                rd_q <= rd_q + 1'b1;
        end
    end

    // Entry storage; contents are don't-care once pointers are cleared.
    always_ff @(posedge clk) begin
        if (push_i && !full_o)
            mem_q[wr_q[PW-1:0]] <= din_i;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x64 integer register file.
// Primary writeback wins by default; the secondary (long-latency) source
// is queued and drained on idle primary cycles. A per-register busy
// scoreboard blocks duplicate destinations so per-register order holds.
// Optional starvation guard: define WB_ARB_STARVE_GUARD_EN to enable the
// lost-arbitration counter and the stall_p FSM; otherwise stall_p is 0.
module regfile_wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = REG_DATA_W,
    parameter int ADDRESS_WIDTH = REG_ADDR_W,
    parameter int FIFO_DEPTH    = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        p_valid,
    input  logic [ADDRESS_WIDTH-1:0]    p_wa,
    input  logic [DATA_WIDTH-1:0]       p_wd,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [ADDRESS_WIDTH-1:0]    s_wa,
    input  logic [DATA_WIDTH-1:0]       s_wd,
    output logic                        RegWrite,
    output logic [ADDRESS_WIDTH-1:0]    wa,
    output logic [DATA_WIDTH-1:0]       wd,
    output logic [2**ADDRESS_WIDTH-1:0] busy,
    output logic                        stall_p
);

    localparam int NREG = 2**ADDRESS_WIDTH;

    wb_req_t s_req, head;
    logic    fifo_full, fifo_empty, fifo_has;
    logic    push, pop, p_req, p_grant, stall_active;

    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] wa_q, wa_d;
    logic [DATA_WIDTH-1:0]    wd_q, wd_d;
    logic [NREG-1:0]          busy_q, busy_d;

    // Writes to r0 are meaningless: primary ones are ignored, secondary
    // ones are handshaken but never queued.
    assign p_req   = p_valid && (p_wa != '0);
    assign s_ready = !fifo_full && !busy_q[s_wa];
    assign push    = s_valid && s_ready && (s_wa != '0);
    assign s_req   = '{valid: 1'b1, wa: s_wa, wd: s_wd};
    assign fifo_has = !fifo_empty && head.valid;

    wb_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (s_req),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Grant selection: a forced stall drains the head, otherwise primary
    // first, otherwise the queue head on primary idle cycles.
    always_comb begin
        pop     = 1'b0;
        p_grant = 1'b0;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        if (fifo_has && (stall_active || !p_req)) begin
            pop  = 1'b1;
            we_d = 1'b1;
            wa_d = head.wa;
            wd_d = head.wd;
        end else if (p_req) begin
            p_grant = 1'b1;
            we_d    = 1'b1;
            wa_d    = p_wa;
            wd_d    = p_wd;
        end
    end

    // Scoreboard: set on enqueue, clear on grant of the queued write.
    always_comb begin
        busy_d = busy_q;
        if (pop)
            busy_d[head.wa] = 1'b0;
        if (push)
            busy_d[s_wa] = 1'b1;
    end

    // Registered write port and scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            busy_q <= '0;
        end else begin
            we_q   <= we_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            busy_q <= busy_d;
        end
    end

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    stall_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Stall FSM and lost-arbitration counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count primary wins over a waiting queue; stall once the limit is hit
    // and release after the forced pop.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (pop || fifo_empty)
            cnt_d = '0;
        else if (p_grant)
            cnt_d = cnt_q + CW'(1);
        case (state_q)
            ST_IDLE:  if (cnt_d == CW'(STARVE_LIMIT)) state_d = ST_STALL;
            ST_STALL: if (pop || fifo_empty)          state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign stall_active = (state_q == ST_STALL);
`else
    assign stall_active = 1'b0;
`endif

    assign stall_p  = stall_active;
    assign RegWrite = we_q;
    assign wa       = wa_q;
    assign wd       = wd_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed
// by random traffic, all compared against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
`ifdef WB_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          p_valid, s_valid, s_ready, RegWrite, stall_p;
    logic [AW-1:0] p_wa, s_wa, wa;
    logic [DW-1:0] p_wd, s_wd, wd;
    logic [31:0]   busy;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_wa(p_wa), .p_wd(p_wd),
        .s_valid(s_valid), .s_ready(s_ready), .s_wa(s_wa), .s_wd(s_wd),
        .RegWrite(RegWrite), .wa(wa), .wd(wd), .busy(busy), .stall_p(stall_p)
    );

    // Reference model: queue of pending secondary writes plus the
    // "consecutive lost arbitrations" count and the resulting stall flag.
    typedef struct {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } ent_t;

    ent_t          mq[$];
    int            m_lost;
    bit            m_stall, m_we;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit queued(input logic [AW-1:0] a);
        foreach (mq[i]) if (mq[i].wa == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        foreach (mq[i]) b[mq[i].wa] = 1'b1;
        return b;
    endfunction

    function automatic bit m_ready(input logic [AW-1:0] a);
        return (mq.size() < DEPTH) && !queued(a);
    endfunction

    task automatic set_in(input bit pv, input int pa, input logic [DW-1:0] pd,
                          input bit sv, input int sa, input logic [DW-1:0] sd);
        p_valid = pv; p_wa = AW'(pa); p_wd = pd;
        s_valid = sv; s_wa = AW'(sa); s_wd = sd;
    endtask

    // One clock: check combinational/contract state before the edge, advance
    // the model, then check the registered outputs after the edge.
    task automatic tick();
        int n;
        bit acc, preq, popped, pwin;
        #1;
        chk("contract_p_during_stall", p_valid && stall_p, 0);
        chk("contract_p_to_busy", p_valid && (p_wa != '0) && busy[p_wa], 0);
        chk("s_ready", s_ready, m_ready(s_wa));
        n      = mq.size();
        acc    = s_valid && m_ready(s_wa);
        preq   = p_valid && (p_wa != '0);
        popped = 1'b0;
        pwin   = 1'b0;
        if (n > 0 && (m_stall || !preq)) popped = 1'b1;
        else if (preq)                   pwin   = 1'b1;
        if (popped) begin
            m_we = 1'b1; m_wa = mq[0].wa; m_wd = mq[0].wd;
            void'(mq.pop_front());
        end else if (pwin) begin
            m_we = 1'b1; m_wa = p_wa; m_wd = p_wd;
        end else begin
            m_we = 1'b0;
        end
        if (GUARD) begin
            if (popped || n == 0) m_lost = 0;
            else if (pwin)        m_lost++;
            if (m_stall) m_stall = !(popped || n == 0);
            else         m_stall = (m_lost == LIMIT);
        end
        if (acc && s_wa != '0) mq.push_back('{wa: s_wa, wd: s_wd});
        @(posedge clk);
        #1;
        chk("RegWrite", RegWrite, m_we);
        if (m_we) begin
            chk("wa", wa, m_wa);
            chk("wd", wd, m_wd);
        end
        chk("busy", busy, m_busy());
        chk("stall_p", stall_p, m_stall);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        mq.delete();
        m_lost = 0; m_stall = 1'b0; m_we = 1'b0; m_wa = '0; m_wd = '0;
        chk("rst_RegWrite", RegWrite, 0);
        chk("rst_wa", wa, 0);
        chk("rst_wd", wd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall_p", stall_p, 0);
        chk("rst_s_ready", s_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int first_stall;
        int post_wa;
        bit got_post;

        rst = 1'b0;
        set_in(0, 0, '0, 0, 0, '0);
        @(negedge clk);
        do_reset();

        // Primary write goes straight through with one cycle of latency.
        set_in(1, 5, 64'hAA, 0, 0, '0);
        tick();
        chk("p_write_we", RegWrite, 1);
        chk("p_write_wa", wa, 5);
        chk("p_write_wd", wd, 64'hAA);
        chk("p_write_busy", busy, 0);

        // Secondary push with primary idle: busy at once, write one edge later.
        set_in(0, 0, '0, 1, 7, 64'h11);
        tick();
        chk("s_push_busy7", busy[7], 1);
        chk("s_push_no_we", RegWrite, 0);
        set_in(0, 0, '0, 0, 0, '0);
        tick();
        chk("s_write_wa", wa, 7);
        chk("s_write_wd", wd, 64'h11);
        chk("s_pop_busy7", busy[7], 0);

        // Duplicate destination is held off until the first write is granted.
        set_in(0, 0, '0, 1, 3, 64'h31);
        tick();
        set_in(1, 9, 64'h99, 1, 3, 64'h32);
        tick();
        set_in(0, 0, '0, 1, 3, 64'h32);
        chk("dup_blocked", s_ready, 0);
        tick();
        chk("dup_released", s_ready, 1);
        tick();
        set_in(0, 0, '0, 0, 0, '0);
        tick();

        // Two queued entries under continuous primary traffic.
        first_stall = -1; post_wa = 0; got_post = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_in(!m_stall, 1 + i, 64'(i), i < 2, 10 + i, 64'h100 + 64'(i));
            tick();
            if (stall_p && first_stall < 0) first_stall = i;
            if (!got_post && RegWrite && wa >= 10) begin
                post_wa = int'(wa); got_post = 1'b1;
            end
        end
        chk("stall_first_cycle", first_stall, GUARD ? 4 : -1);
        chk("stall_forced_head", post_wa, GUARD ? 10 : 0);
        set_in(0, 0, '0, 0, 0, '0);
        repeat (3) tick();

        // Address zero on both sides: nothing written, nothing tracked.
        set_in(1, 0, 64'hDEAD, 1, 0, 64'hBEEF);
        tick();
        chk("zero_no_we", RegWrite, 0);
        chk("zero_busy", busy, 0);
        chk("zero_s_ready", s_ready, 1);

        // Reset with two queued entries flushes them.
        set_in(1, 20, 64'h20, 1, 12, 64'h12);
        tick();
        set_in(1, 21, 64'h21, 1, 13, 64'h13);
        tick();
        chk("prereset_busy", busy, 32'h0000_3000);
        set_in(0, 0, '0, 0, 0, '0);
        do_reset();
        repeat (3) tick();

        // Random traffic obeying the primary-side contract.
        for (int i = 0; i < 400; i++) begin
            bit          pv;
            logic [AW-1:0] pa;
            pv = ($urandom_range(3) != 0);
            pa = AW'($urandom_range(31));
            if (m_stall || queued(pa)) pv = 1'b0;
            set_in(pv, int'(pa), {$urandom, $urandom},
                   $urandom_range(1) == 1, $urandom_range(7), {$urandom, $urandom});
            tick();
            if (i == 200) begin
                set_in(0, 0, '0, 0, 0, '0);
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
